// File: rtl/sram_ctrl_pkg.sv
`timescale 1ns/1ps
// sram_ctrl_pkg
// Shared types and constants for the SRAM port controller (sram_port_ctrl)
// and its read-response buffer (sram_resp_fifo).
//   ctrl_state_e : controller phase, INIT (zero-filling) or RUN (serving requests)
//   RESP_DEPTH   : number of read responses the buffer can hold
//   RESP_CNT_W   : width of an occupancy count covering 0..RESP_DEPTH
package sram_ctrl_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_e;

    localparam int RESP_DEPTH = 2;
    localparam int RESP_CNT_W = $clog2(RESP_DEPTH + 1);

endpackage

// File: rtl/sram_resp_fifo.sv
`timescale 1ns/1ps
// sram_resp_fifo
// Two-entry flop-based FIFO that holds read data captured from the SRAM
// until the consumer takes it. The head entry is always presented on dout.
// There is no bypass from din to dout: data pushed in one cycle is visible
// from the next cycle on.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   push, din  : write din into the tail (caller guarantees room, or a pop)
//   pop        : discard the head entry (ignored when empty)
//   dout       : head entry data (reset value 0)
//   count      : current occupancy, 0..RESP_DEPTH
module sram_resp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic [RESP_CNT_W-1:0] count
);

    localparam logic [RESP_CNT_W-1:0] FULL_CNT = RESP_CNT_W'(RESP_DEPTH);
    localparam logic [RESP_CNT_W-1:0] ONE_CNT  = RESP_CNT_W'(1);

    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic             pop_ok;
    logic             push_ok;

    // A pop on an empty buffer is dropped; a push into a full buffer is only
    // legal when the head leaves in the same cycle.
    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && ((count != FULL_CNT) || pop_ok);
    assign dout    = head_q;

    // Head/tail storage. On a simultaneous push and pop the occupancy stays
    // the same: with one entry the new word lands straight in the head, with
    // two entries the tail moves up and the new word takes the tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            count  <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (count == '0) begin
                        head_q <= din;
                    end else begin
                        tail_q <= din;
                    end
                    count <= count + ONE_CNT;
                end
                2'b01: begin
                    head_q <= tail_q;
                    count  <= count - ONE_CNT;
                end
                2'b11: begin
                    if (count == ONE_CNT) begin
                        head_q <= din;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/sram_port_ctrl.sv
`timescale 1ns/1ps
// sram_port_ctrl
// Initiator-side controller for a single-port synchronous SRAM macro whose
// read data is registered one cycle after a read enable. Turns a valid/ready
// request channel into raw SRAM enables, and returns read data through a
// valid/ready response channel backed by a two-entry buffer. Optionally
// zero-fills the whole array after reset before accepting any request.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   req_valid/req_ready         : request handshake
//   req_we, req_addr, req_wdata : write flag, word address, write data
//   resp_valid/resp_ready       : response handshake (head of buffer)
//   resp_rdata                  : read data at buffer head
//   init_done                   : high once the zero-fill has finished
//   sram_en, sram_we            : SRAM enable / write enable
//   sram_addr, sram_wdata       : SRAM address / write data
//   sram_rdata                  : SRAM registered read data
module sram_port_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int  WIDTH          = 32,
    parameter int  DEPTH          = 256,
    parameter bit  CLEAR_ON_RESET = 1'b1,
    localparam int AW             = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [AW-1:0]    req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             init_done,
    output logic             sram_en,
    output logic             sram_we,
    output logic [AW-1:0]    sram_addr,
    output logic [WIDTH-1:0] sram_wdata,
    input  logic [WIDTH-1:0] sram_rdata
);

    localparam ctrl_state_e   RESET_STATE = CLEAR_ON_RESET ? INIT : RUN;
    localparam logic [AW-1:0] LAST_ADDR   = AW'(DEPTH - 1);
    localparam logic [2:0]    RESP_LIMIT  = 3'(RESP_DEPTH);

    ctrl_state_e           state;
    logic [AW-1:0]         clr_addr;
    logic                  inflight;
    logic [RESP_CNT_W-1:0] fifo_count;
    logic                  pop;
    logic                  issue;
    logic                  rd_issue;
    logic [2:0]            pending;
    logic                  rd_room;

    // Reads already committed to the buffer are the buffered ones plus the
    // one whose data arrives this cycle; a pop this cycle frees one slot.
    // The result never depends on req_valid, only on the request type.
    assign pop        = resp_valid && resp_ready;
    assign resp_valid = (fifo_count != '0);
    assign pending    = 3'(fifo_count) + 3'(inflight) - 3'(pop);
    assign rd_room    = (pending < RESP_LIMIT);
    assign req_ready  = (state == RUN) && (req_we || rd_room);
    assign issue      = req_valid && req_ready;
    assign rd_issue   = issue && !req_we;

    // Phase control. While clearing, the address counter walks 0..DEPTH-1
    // and holds on the last address so it never wraps; the switch to RUN and
    // init_done both happen on the edge that completes the last write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RESET_STATE;
            clr_addr  <= '0;
            init_done <= !CLEAR_ON_RESET;
        end else if (state == INIT) begin
            if (clr_addr == LAST_ADDR) begin
                state     <= RUN;
                init_done <= 1'b1;
            end else begin
                clr_addr <= clr_addr + 1'b1;
            end
        end
    end

    // The SRAM returns read data one cycle after the enable; this flag marks
    // the cycle in which sram_rdata must be captured into the buffer. Any
    // write issued in that cycle leaves the macro's read register untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= rd_issue;
        end
    end

    // SRAM port drive: zero-fill writes during INIT, otherwise the accepted
    // request passes straight through. Everything is zero when idle.
    always_comb begin
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (state == INIT) begin
            sram_en   = 1'b1;
            sram_we   = 1'b1;
            sram_addr = clr_addr;
        end else if (issue) begin
            sram_en    = 1'b1;
            sram_we    = req_we;
            sram_addr  = req_addr;
            sram_wdata = req_wdata;
        end
    end

    sram_resp_fifo #(
        .WIDTH (WIDTH)
    ) u_resp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight),
        .pop   (pop),
        .din   (sram_rdata),
        .dout  (resp_rdata),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_sram_port_ctrl.sv
`timescale 1ns/1ps
// tb_sram_port_ctrl
// Bench for sram_port_ctrl with a behavioural SRAM macro attached. A model
// keeps a reference memory and a queue of expected read responses, and on
// every falling clock edge checks all DUT outputs against it. Directed
// sequences add literal expectations on response data and latency.
module tb_sram_port_ctrl;

    localparam int WIDTH = 32;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic             clk        = 1'b0;
    logic             rst_n      = 1'b0;
    logic             req_valid  = 1'b0;
    logic             req_ready;
    logic             req_we     = 1'b0;
    logic [AW-1:0]    req_addr   = '0;
    logic [WIDTH-1:0] req_wdata  = '0;
    logic             resp_valid;
    logic             resp_ready = 1'b1;
    logic [WIDTH-1:0] resp_rdata;
    logic             init_done;
    logic             sram_en;
    logic             sram_we;
    logic [AW-1:0]    sram_addr;
    logic [WIDTH-1:0] sram_wdata;
    logic [WIDTH-1:0] sram_rdata;

    int checks = 0;
    int errors = 0;

    sram_port_ctrl #(
        .WIDTH          (WIDTH),
        .DEPTH          (DEPTH),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .init_done  (init_done),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM macro: starts full of non-zero junk so the zero-fill
    // is visible, registers read data on a read enable, keeps it on writes.
    logic [WIDTH-1:0] sram_mem [DEPTH];
    logic             sram_fill = 1'b1;

    always @(posedge clk) begin
        if (sram_fill) begin
            for (int i = 0; i < DEPTH; i++) begin
                sram_mem[i] <= 32'hA5A5_0000 | i;
            end
            sram_rdata <= 32'hBAD0_BAD0;
            sram_fill  <= 1'b0;
        end else if (sram_en) begin
            if (sram_we) begin
                sram_mem[sram_addr] <= sram_wdata;
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    typedef struct packed {
        logic [WIDTH-1:0] data;
        int               acc_cyc;
    } exp_t;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        int               lat;
    } pop_t;

    exp_t             exp_q[$];
    pop_t             pop_log[$];
    logic [WIDTH-1:0] ref_mem [DEPTH];
    int               cyc = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
        end
    endtask

    // Reference model: the first DEPTH cycles after reset are zero-fill
    // writes with no requests taken; afterwards writes are always taken and
    // a read is taken while fewer than two earlier reads are still unpopped
    // (counting a pop in the same cycle). A read's data is the memory value
    // at acceptance and it is offered from two cycles later, in order.
    always @(negedge clk) begin
        logic             in_init;
        logic             exp_valid;
        logic             exp_pop;
        logic             exp_ready;
        logic             issue;
        logic             exp_en;
        logic             exp_we;
        logic [AW-1:0]    exp_addr;
        logic [WIDTH-1:0] exp_wdata;
        if (!rst_n) begin
            exp_q.delete();
            cyc = 0;
        end else begin
            in_init   = (cyc < DEPTH);
            exp_valid = 1'b0;
            if (exp_q.size() > 0) begin
                exp_valid = (cyc >= exp_q[0].acc_cyc + 2);
            end
            exp_pop   = exp_valid && resp_ready;
            exp_ready = !in_init && (req_we || ((exp_q.size() - int'(exp_pop)) < 2));
            issue     = !in_init && req_valid && exp_ready;
            if (in_init) begin
                exp_en    = 1'b1;
                exp_we    = 1'b1;
                exp_addr  = cyc[AW-1:0];
                exp_wdata = '0;
            end else begin
                exp_en    = issue;
                exp_we    = issue && req_we;
                exp_addr  = issue ? req_addr : '0;
                exp_wdata = issue ? req_wdata : '0;
            end

            checkOutput("init_done", init_done, !in_init);
            checkOutput("req_ready", req_ready, exp_ready);
            checkOutput("resp_valid", resp_valid, exp_valid);
            if (exp_valid) begin
                checkOutput("resp_rdata", resp_rdata, exp_q[0].data);
            end
            checkOutput("sram_en", sram_en, exp_en);
            checkOutput("sram_we", sram_we, exp_we);
            checkOutput("sram_addr", sram_addr, exp_addr);
            checkOutput("sram_wdata", sram_wdata, exp_wdata);

            if (exp_pop) begin
                pop_log.push_back('{exp_q[0].data, cyc - exp_q[0].acc_cyc});
                void'(exp_q.pop_front());
            end
            if (in_init) begin
                ref_mem[cyc[AW-1:0]] = '0;
            end else if (issue) begin
                if (req_we) begin
                    ref_mem[req_addr] = req_wdata;
                end else begin
                    exp_q.push_back('{ref_mem[req_addr], cyc});
                end
            end
            cyc++;
        end
    end

    task automatic toNextDrive();
        @(posedge clk);
        #1;
    endtask

    // Present one request and hold it until accepted; waited counts the
    // cycles it was refused. Returns one time unit after the accepting edge.
    task automatic applyStimulus(input logic we, input logic [AW-1:0] addr,
                                 input logic [WIDTH-1:0] wdata, output int waited);
        logic acc;
        acc       = 1'b0;
        waited    = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            acc = req_ready;
            toNextDrive();
            if (acc) break;
            waited++;
        end
        if (!acc) begin
            checkOutput("accept_timeout", 64'd0, 64'd1);
        end
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic waitPops(input int target);
        for (int k = 0; k < 40; k++) begin
            if (pop_log.size() >= target) break;
            @(negedge clk);
        end
        if (pop_log.size() < target) begin
            checkOutput("pop_timeout", pop_log.size(), target);
        end
        toNextDrive();
    endtask

    // Count the cycles before init_done rises and how many of them carry a
    // zero write to the expected sequential address with requests blocked.
    task automatic waitInit(output int cycles, output int writes);
        cycles = 0;
        writes = 0;
        for (int k = 0; k < DEPTH + 20; k++) begin
            @(negedge clk);
            if (init_done) break;
            if (sram_en && sram_we && (sram_addr == AW'(cycles)) &&
                (sram_wdata == '0) && !req_ready) begin
                writes++;
            end
            cycles++;
        end
    endtask

    initial begin
        int            n;
        int            good;
        int            waited;
        int            max_wait;
        int            accepted;
        int            base;
        int            logged;
        logic          acc;
        logic [AW-1:0] a;
        logic [AW-1:0] a_next;

        $display("[TB] starting sram_port_ctrl bench");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        waitInit(n, good);
        checkOutput("init_cycles", n, 256);
        checkOutput("init_writes", good, 256);
        toNextDrive();

        // Cleared location reads back as zero, two cycles after acceptance.
        base = pop_log.size();
        applyStimulus(1'b0, 8'h7F, '0, waited);
        waitPops(base + 1);
        checkOutput("clear_rd_data", pop_log[base].data, 32'h0);
        checkOutput("clear_rd_lat", pop_log[base].lat, 2);

        // Write followed immediately by a read of the same word.
        base = pop_log.size();
        applyStimulus(1'b1, 8'h10, 32'hDEAD_BEEF, waited);
        applyStimulus(1'b0, 8'h10, '0, waited);
        waitPops(base + 1);
        checkOutput("raw_data", pop_log[base].data, 32'hDEAD_BEEF);
        checkOutput("raw_lat", pop_log[base].lat, 2);

        // Sixteen back-to-back reads at full rate.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, AW'(i), WIDTH'(i * 3), waited);
        end
        base     = pop_log.size();
        max_wait = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, AW'(i), '0, waited);
            if (waited > max_wait) max_wait = waited;
        end
        checkOutput("b2b_stall", max_wait, 0);
        waitPops(base + 16);
        for (int i = 0; i < 16; i++) begin
            checkOutput("b2b_data", pop_log[base + i].data, i * 3);
            checkOutput("b2b_lat", pop_log[base + i].lat, 2);
        end

        // Back-pressure: only two reads get in, writes still do.
        resp_ready = 1'b0;
        base       = pop_log.size();
        accepted   = 0;
        a          = '0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = a;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            acc = req_ready;
            toNextDrive();
            if (acc) begin
                accepted++;
                a        = a + 8'd1;
                req_addr = a;
            end
        end
        req_valid = 1'b0;
        checkOutput("bp_accepts", accepted, 2);
        applyStimulus(1'b1, 8'h20, 32'h1234_5678, waited);
        checkOutput("bp_write_wait", waited, 0);
        resp_ready = 1'b1;
        a_next     = a + 8'd1;
        applyStimulus(1'b0, a, '0, waited);
        applyStimulus(1'b0, a_next, '0, waited);
        waitPops(base + 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("bp_data", pop_log[base + i].data, i * 3);
        end

        // Read then overwrite the same word: the read keeps the old value.
        applyStimulus(1'b1, 8'h05, 32'h55, waited);
        base = pop_log.size();
        applyStimulus(1'b0, 8'h05, '0, waited);
        applyStimulus(1'b1, 8'h05, 32'hAA, waited);
        applyStimulus(1'b0, 8'h05, '0, waited);
        waitPops(base + 2);
        checkOutput("war_old", pop_log[base].data, 32'h55);
        checkOutput("war_new", pop_log[base + 1].data, 32'hAA);

        // Reset with two responses buffered.
        resp_ready = 1'b0;
        applyStimulus(1'b0, 8'h10, '0, waited);
        applyStimulus(1'b0, 8'h05, '0, waited);
        toNextDrive();
        toNextDrive();
        checkOutput("pre_rst_valid", resp_valid, 1);
        logged = pop_log.size();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_resp_valid", resp_valid, 0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
        checkOutput("rst_init_done", init_done, 0);
        checkOutput("rst_req_ready", req_ready, 0);
        resp_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        waitInit(n, good);
        checkOutput("reinit_cycles", n, 256);
        checkOutput("reinit_writes", good, 256);
        toNextDrive();
        repeat (5) toNextDrive();
        checkOutput("no_stale", pop_log.size(), logged);

        base = pop_log.size();
        applyStimulus(1'b0, 8'h10, '0, waited);
        waitPops(base + 1);
        checkOutput("reclear_data", pop_log[base].data, 32'h0);
        checkOutput("reclear_lat", pop_log[base].lat, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
